// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB first.
// Loads I when SL=1, logically shifts right with zero fill when SL=0.
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] I,
  input  logic             SL,
  input  logic             clk,
  input  logic             reset,
  output logic             q
);

  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = {1'b0, r_reg[WIDTH-1:1]};
    if (SL) w_next = I;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_reg <= '0;
    else       r_reg <= w_next;
  end

  // Registered output only; no path from I or SL.
  assign q = r_reg[0];

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg, WIDTH=4 and WIDTH=8 instances.
// Expected values are queued at drive time and popped after each edge.
module tb_piso_shift_reg;

  logic       clk;
  logic       reset;
  logic [3:0] i4;
  logic       sl4;
  logic       q4;
  logic [7:0] i8;
  logic       sl8;
  logic       q8;

  int n_chk;
  int n_pass;

  logic       exp_q[$];
  logic [7:0] exp_r[$];

  piso_shift_reg #(.WIDTH(4)) u4 (
    .I(i4), .SL(sl4), .clk(clk), .reset(reset), .q(q4)
  );

  piso_shift_reg #(.WIDTH(8)) u8 (
    .I(i8), .SL(sl8), .clk(clk), .reset(reset), .q(q8)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive4(input string tag, input logic sl,
                        input logic [3:0] din, input logic eq,
                        input logic [3:0] er);
    logic       pq;
    logic [7:0] pr;
    @(negedge clk);
    sl4 = sl;
    i4  = din;
    exp_q.push_back(eq);
    exp_r.push_back({4'b0, er});
    @(posedge clk);
    #1;
    pq = exp_q.pop_front();
    pr = exp_r.pop_front();
    chk({tag, "_q"}, {7'b0, q4}, {7'b0, pq});
    chk({tag, "_r"}, {4'b0, u4.r_reg}, pr);
  endtask

  task automatic drive8(input string tag, input logic sl,
                        input logic [7:0] din, input logic eq,
                        input logic [7:0] er);
    logic       pq;
    logic [7:0] pr;
    @(negedge clk);
    sl8 = sl;
    i8  = din;
    exp_q.push_back(eq);
    exp_r.push_back(er);
    @(posedge clk);
    #1;
    pq = exp_q.pop_front();
    pr = exp_r.pop_front();
    chk({tag, "_q"}, {7'b0, q8}, {7'b0, pq});
    chk({tag, "_r"}, u8.r_reg, pr);
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] a5_q;
    n_chk  = 0;
    n_pass = 0;
    a5     = 8'hA5;
    a5_q   = 8'b1010_0101;

    reset = 1'b1;
    sl4   = 1'bx;
    i4    = 4'bx;
    sl8   = 1'b0;
    i8    = 8'h00;
    #5;
    chk("rst_now_q", {7'b0, q4}, 8'h00);
    chk("rst_now_r", {4'b0, u4.r_reg}, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_edge_q", {7'b0, q4}, 8'h00);
    sl4 = 1'b1;
    i4  = 4'b1111;
    @(posedge clk);
    #1;
    chk("rst_prio_q", {7'b0, q4}, 8'h00);
    chk("rst_prio_r", {4'b0, u4.r_reg}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    drive4("ld0", 1'b1, 4'b1001, 1'b1, 4'b1001);
    drive4("ld1", 1'b1, 4'b1011, 1'b1, 4'b1011);
    drive4("ld2", 1'b1, 4'b1000, 1'b0, 4'b1000);

    drive4("so_ld", 1'b1, 4'b1011, 1'b1, 4'b1011);
    drive4("so_s1", 1'b0, 4'b0000, 1'b1, 4'b0101);
    drive4("so_s2", 1'b0, 4'b0000, 1'b0, 4'b0010);
    drive4("so_s3", 1'b0, 4'b0000, 1'b1, 4'b0001);
    drive4("so_s4", 1'b0, 4'b1111, 1'b0, 4'b0000);
    drive4("so_s5", 1'b0, 4'b0000, 1'b0, 4'b0000);

    drive4("rl_ld", 1'b1, 4'b0110, 1'b0, 4'b0110);
    drive4("rl_s1", 1'b0, 4'b0000, 1'b1, 4'b0011);
    drive4("rl_ld2", 1'b1, 4'b0001, 1'b1, 4'b0001);
    drive4("rl_s2", 1'b0, 4'b0000, 1'b0, 4'b0000);

    drive4("ar_ld", 1'b1, 4'b1111, 1'b1, 4'b1111);
    drive4("ar_s1", 1'b0, 4'b0000, 1'b1, 4'b0111);
    drive4("ar_s2", 1'b0, 4'b0000, 1'b1, 4'b0011);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_async_q", {7'b0, q4}, 8'h00);
    chk("ar_async_r", {4'b0, u4.r_reg}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    drive4("ar_post1", 1'b0, 4'b1111, 1'b0, 4'b0000);
    drive4("ar_post2", 1'b0, 4'b1111, 1'b0, 4'b0000);

    sl4 = 1'b0;
    drive8("w8_ld", 1'b1, a5, a5_q[0], a5);
    for (int k = 1; k <= 8; k++) begin
      logic eq;
      eq = (k < 8) ? a5_q[k] : 1'b0;
      drive8($sformatf("w8_s%0d", k), 1'b0, 8'h00, eq, a5 >> k);
    end
    drive8("w8_s9", 1'b0, 8'hFF, 1'b0, 8'h00);

    chk("sb_empty", 8'(exp_q.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
